arbitro_etiquetas: RTL and testbench
====================================

# arbitro_etiquetas

Two-requester arbiter and sequencer for the shared tag-array lookup port. It grants one requester at a time, drives the select line of the external 2:1 tag mux, and issues a one-cycle strobe to the tag array. It holds the grant until the array acknowledges, then pulses a per-requester done. It sits between the instruction-side (requester 0) and data-side (requester 1) tag lookups and the single tag comparison path.

## Interface
- K, 1: width of the tag field, carried for package consistency. No internal datapath uses it; the mux itself is external.
- TMO, 15: timeout in cycles spent in WAIT. Used only when ARB_TIMEOUT_EN is defined. Legal range is 1 or more.
- Clock and reset are fixed: one clock, CLK; reset RST is asynchronous and active-high.
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- REQ0  in  1  lookup request, requester 0
- REQ1  in  1  lookup request, requester 1
- ACK  in  1  tag array lookup complete, one-cycle pulse
- SEL  out  1  external tag mux select (0 = requester 0, 1 = requester 1)
- GNT0  out  1  grant to requester 0
- GNT1  out  1  grant to requester 1
- STB  out  1  lookup start strobe to tag array
- DONE0  out  1  completion pulse to requester 0
- DONE1  out  1  completion pulse to requester 1
- ERR  out  1  timeout pulse

## Operation
- All outputs are registered. On reset: SEL=0, GNT0=GNT1=0, STB=0, DONE0=DONE1=0, ERR=0, state=IDLE. The last-served register LAST resets to 1, so requester 0 wins the first tie.
- **IDLE**
  - If neither REQ is high: stay; SEL keeps its previous value.
  - If exactly one REQ is high: grant that requester.
  - If both REQ are high: grant the requester that is not LAST (round-robin).
  - On grant: set SEL and GNTx, go to ISSUE.
  - In the cycle DONEx is high, REQx is masked, so the just-served requester cannot re-win on its stale request.
- **ISSUE**: STB=1 for exactly this cycle, then go to WAIT. ACK is ignored in this state.
- **WAIT**: SEL and GNTx are held.
  - On ACK: next cycle DONEx=1 and GNTx=0, LAST=x, state=IDLE.
- ACK in IDLE or ISSUE is ignored.
- Dropping REQx while granted does not cancel the transaction; DONEx is still generated.
- Requesters hold REQx until they see DONEx.
- GNT0 and GNT1 are never high together.

## Timing
- Grant latency: REQ sampled in IDLE at edge n gives GNT, SEL and STB valid after edge n.
- STB is high for one cycle. WAIT is entered after edge n+1.
- DONEx is high in the cycle after the ACK sampling edge.
- Minimum transaction is 3 cycles (ISSUE, WAIT, IDLE/DONE). Back-to-back grants start every 3 cycles under continuous contention.
- Reset asserted mid-transaction:
  - Outputs clear asynchronously.
  - No DONE is produced for the aborted lookup.
  - LAST returns to 1.

## Configuration
- **ARB_TIMEOUT_EN defined**
  - A counter clears on entry to WAIT and increments each WAIT cycle without ACK.
  - After TMO WAIT cycles with no ACK, the next cycle has ERR=1, DONEx=1 and GNTx=0, LAST=x, state=IDLE.
  - ACK and timeout in the same cycle: ACK wins and ERR=0.
  - Counter width is $clog2(TMO+1).
- **ARB_TIMEOUT_EN undefined**: WAIT exits only on ACK, ERR is tied to 0, and TMO is unused.

## Structure
- Package arbitro_pkg holds:
  - estado_t enum: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10.
  - Default constants for K and TMO.
  - Requester index constants REQ_I=0, REQ_D=1.
- Sub-module contador_timeout (load-clear, enable, terminal-count flag) is instantiated only under ARB_TIMEOUT_EN.
- The 2:1 tag mux stays outside this block; only SEL crosses the boundary.

## Test plan
- **Reset:** RST=1 for 2 cycles with REQ0=REQ1=1 gives SEL=0, GNT=00, STB=0, DONE=00, ERR=0 throughout. After release, requester 0 is granted first.
- **Single request:** REQ1 rises at cycle 2, ACK pulses 3 cycles after STB.
  - GNT1=SEL=1 from cycle 3 and STB=1 in cycle 3.
  - DONE1 pulses for one cycle right after ACK.
  - GNT0 never asserts.
- **Contention:** REQ0=REQ1=1 held, ACK one cycle after each STB. Grants alternate 0,1,0,1 at a 3-cycle spacing; SEL tracks the grant.
- **Reset mid-op:** RST pulses during WAIT of a requester-1 lookup. Outputs go to 0 immediately, no DONE1 appears, and the next grant goes to requester 0.
- **Timeout:** TMO=4 with ARB_TIMEOUT_EN and no ACK gives ERR=DONE0=1 one cycle after 4 WAIT cycles. Without the macro, the design stays in WAIT with GNT0=1 indefinitely.
- **Spurious ACK:** ACK pulsed in IDLE and in ISSUE produces no DONE and no state change.

Source files
------------

// File: rtl/arbitro_etiquetas_pkg.sv
// arbitro_pkg: shared types and constants for the tag-lookup arbiter
// (arbitro_etiquetas). The optional WAIT timeout is enabled with the
// ARB_TIMEOUT_EN macro; this package is identical in both builds.
package arbitro_pkg;

  // Sequencer states for one tag-array lookup.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } estado_t;

  // Default tag width (carried for consistency with the external mux).
  localparam int K_DEF   = 1;
  // Default number of WAIT cycles before a lookup is abandoned.
  localparam int TMO_DEF = 15;

  // Requester indices: instruction side and data side.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arbitro_etiquetas_contador.sv
// contador_timeout: clearable up-counter with a terminal-count flag,
// used by arbitro_etiquetas to bound the WAIT state. Only instantiated
// when ARB_TIMEOUT_EN is defined.
module contador_timeout #(
  parameter int W     = 4,
  parameter int LIMIT = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  // Count enabled cycles since the last clear; park at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(LIMIT));

endmodule

// File: rtl/arbitro_etiquetas.sv
// arbitro_etiquetas: round-robin arbiter/sequencer for the shared
// tag-array lookup port. Requester 0 is the instruction side, requester 1
// the data side. Define ARB_TIMEOUT_EN to abandon a lookup (ERR pulse)
// after TMO WAIT cycles without ACK; otherwise WAIT only exits on ACK.
module arbitro_etiquetas
  import arbitro_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  input  logic ACK,
  output logic SEL,
  output logic GNT0,
  output logic GNT1,
  output logic STB,
  output logic DONE0,
  output logic DONE1,
  output logic ERR
);

  estado_t state;
  logic    last;
  logic    req0_eff;
  logic    req1_eff;
  logic    any_req;
  logic    winner;
  logic    timeout;

  // K only describes the external mux; an illegal value leaves a marker block.
  if (K < 1) begin : g_k_illegal
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  assign cnt_clr = (state == ISSUE);
  assign cnt_en  = (state == WAIT) && !ACK;

  contador_timeout #(
    .W     (CW),
    .LIMIT (TMO - 1)
  ) u_contador (
    .clk (CLK),
    .rst (RST),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  assign timeout = cnt_tc;
`else
  // Without the timeout feature TMO has no effect; keep a marker for bad values.
  if (TMO < 1) begin : g_tmo_illegal
  end

  assign timeout = 1'b0;
`endif

  // Pick the next owner; a requester whose DONE is high this cycle is masked.
  always_comb begin
    req0_eff = REQ0 & ~DONE0;
    req1_eff = REQ1 & ~DONE1;
    any_req  = req0_eff | req1_eff;
    winner   = REQ_I;
    if (req0_eff && req1_eff) begin
      winner = ~last;
    end else if (req1_eff) begin
      winner = REQ_D;
    end
  end

  // Grant / issue / wait sequencer with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
      SEL   <= 1'b0;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      STB   <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      STB   <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            SEL   <= winner;
            GNT0  <= (winner == REQ_I);
            GNT1  <= (winner == REQ_D);
            STB   <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (ACK || timeout) begin
            DONE0 <= (SEL == REQ_I);
            DONE1 <= (SEL == REQ_D);
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            last  <= SEL;
            ERR   <= timeout & ~ACK;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_etiquetas.sv
// tb_arbitro_etiquetas: self-checking bench for arbitro_etiquetas.
// Directed scenarios plus randomized traffic, all compared against a
// transaction-level reference model. Honours ARB_TIMEOUT_EN if defined.
module tb_arbitro_etiquetas;

  localparam int TB_TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic REQ0;
  logic REQ1;
  logic ACK;
  logic SEL;
  logic GNT0;
  logic GNT1;
  logic STB;
  logic DONE0;
  logic DONE1;
  logic ERR;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, whether this is the strobe cycle,
  // who was served last, and what completion (if any) is visible now.
  int m_owner;
  bit m_issue;
  int m_last;
  int m_sel;
  int m_done;
  bit m_err;
  int m_waits;

  arbitro_etiquetas #(
    .K   (1),
    .TMO (TB_TMO)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .ACK   (ACK),
    .SEL   (SEL),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .STB   (STB),
    .DONE0 (DONE0),
    .DONE1 (DONE1),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_issue = 1'b0;
    m_last  = 1;
    m_sel   = 0;
    m_done  = -1;
    m_err   = 1'b0;
    m_waits = 0;
  endtask

  task automatic model_complete(input bit by_timeout);
    m_done  = m_owner;
    m_last  = m_owner;
    m_err   = by_timeout;
    m_owner = -1;
  endtask

  // One clock edge of the model, given the inputs sampled at that edge.
  task automatic model_edge(input logic r0, input logic r1, input logic a);
    int done_prev;
    int pick;
    bit c0;
    bit c1;
    done_prev = m_done;
    m_done    = -1;
    m_err     = 1'b0;
    if (m_owner < 0) begin
      c0 = r0 && (done_prev != 0);
      c1 = r1 && (done_prev != 1);
      if (c0 && c1)  pick = 1 - m_last;
      else if (c1)   pick = 1;
      else if (c0)   pick = 0;
      else           pick = -1;
      if (pick >= 0) begin
        m_owner = pick;
        m_sel   = pick;
        m_issue = 1'b1;
      end
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_waits = 0;
    end else if (a) begin
      model_complete(1'b0);
    end else begin
      m_waits++;
      if (TIMEOUT_ON && m_waits == TB_TMO) model_complete(1'b1);
    end
  endtask

  function automatic bit model_waiting();
    return (m_owner >= 0) && !m_issue;
  endfunction

  task automatic check_all();
    checkOutput("GNT0",  GNT0,  m_owner == 0);
    checkOutput("GNT1",  GNT1,  m_owner == 1);
    checkOutput("STB",   STB,   (m_owner >= 0) && m_issue);
    checkOutput("SEL",   SEL,   m_sel == 1);
    checkOutput("DONE0", DONE0, m_done == 0);
    checkOutput("DONE1", DONE1, m_done == 1);
    checkOutput("ERR",   ERR,   m_err);
  endtask

  // Drive one cycle of inputs from the falling edge, then check after the next rising edge.
  task automatic applyStimulus(input logic r0, input logic r1, input logic a);
    REQ0 = r0;
    REQ1 = r1;
    ACK  = a;
    @(posedge CLK);
    if (RST) model_reset();
    else     model_edge(r0, r1, a);
    @(negedge CLK);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (m_owner < 0 && m_done < 0) break;
      applyStimulus(1'b0, 1'b0, model_waiting());
    end
    checkOutput("drain_idle", GNT0 | GNT1, 1'b0);
  endtask

  initial begin
    int  gap;
    bit  next_d;
    bit  seen_stb;
    int  since;
    bit  got_done;
    bit  r0;
    bit  r1;
    bit  a;

    // Reset with both requests high.
    RST  = 1'b1;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    ACK  = 1'b0;
    model_reset();
    @(negedge CLK);
    check_all();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    RST = 1'b0;

    // Contention: first grant to requester 0, then strict alternation every 3 cycles.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("first_grant_req0", GNT0, 1'b1);
    next_d   = 1'b1;
    gap      = 0;
    seen_stb = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b1, model_waiting());
      gap++;
      if (STB === 1'b1) begin
        checkOutput("alt_order_gnt1", GNT1, next_d);
        checkOutput("alt_sel", SEL, next_d);
        checkOutput("alt_spacing3", gap == 3, 1'b1);
        next_d   = ~next_d;
        gap      = 0;
        seen_stb = 1'b1;
      end
    end
    checkOutput("alt_stb_seen", seen_stb, 1'b1);
    drain();

    // Single request on requester 1, ACK three cycles after the strobe.
    applyStimulus(1'b0, 1'b0, 1'b0);
    since    = -1;
    got_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, !got_done, since == 3);
      if (since >= 0) since++;
      if (STB === 1'b1) since = 0;
      if (DONE1 === 1'b1) got_done = 1'b1;
    end
    checkOutput("single_done1_seen", got_done, 1'b1);
    drain();

    // Spurious ACK in IDLE and in ISSUE.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("ack_in_issue_no_done", DONE0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("real_ack_done0", DONE0, 1'b1);
    drain();

    // Reset during WAIT of a requester-1 lookup.
    for (int i = 0; i < 6; i++) begin
      if (model_waiting() && m_owner == 1) break;
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_gnt1", GNT1, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    check_all();
    RST = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_reset_grant_req0", GNT0, 1'b1);
    drain();

    // No ACK at all: timeout when enabled, otherwise the grant is held.
    applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TB_TMO + 1; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("timeout_err", ERR, 1'b1);
    checkOutput("timeout_done0", DONE0, 1'b1);
`else
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold_gnt0", GNT0, 1'b1);
    checkOutput("hold_no_err", ERR, 1'b0);
`endif
    drain();

    // Randomized traffic with spurious ACKs.
    for (int i = 0; i < 400; i++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      if (model_waiting()) a = ($urandom_range(0, 2) == 0);
      else                 a = ($urandom_range(0, 7) == 0);
      applyStimulus(r0, r1, a);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
